filter_frame_ctrl: RTL and testbench
====================================

# filter_frame_ctrl

Frame-synchronous controller for the pixel threshold filter on the VGA path. It tracks VGA timing (HS/VS/BLANK_N) to derive pixel position and frame boundaries, and counts the filter's per-pixel match flag over each frame. At each vertical-sync boundary it publishes the count and updates the green threshold driven into the filter datapath, either from the manual switch value or by closed-loop auto-adjustment toward a target count. The threshold never changes mid-frame.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- CNT_W, 19, match-counter width (holds WIDTH*HEIGHT)
- STEP, 1, auto-adjust threshold increment per frame
- HYST, 64, auto-adjust deadband half-width (matches)

Ports:
- VGA_CLK  in  1  pixel clock (25 MHz); single clock domain
- reset_n  in  1  asynchronous, active-low reset
- iVGA_HS  in  1  horizontal sync, low between lines
- iVGA_VS  in  1  vertical sync, low between frames
- iVGA_BLANK_N  in  1  high during active pixels
- match  in  1  filter match flag, same cycle as iVGA_*; meaningful only when iVGA_BLANK_N=1
- sw_thresh  in  8  manual threshold
- auto_en  in  1  1 selects auto-adjust; sampled at boundary
- target  in  CNT_W  desired matches per frame
- thresh  out  8  threshold to filter datapath
- frame_count  out  CNT_W  matches in last completed frame
- count_valid  out  1  one-cycle pulse when frame_count updates
- pix_x  out  10  column of current active pixel
- pix_y  out  9  line of current active pixel
- overflow  out  1  sticky timing-violation flag

## Operation
- Boundary: a cycle with prev_vs=1 and iVGA_VS=0, where prev_vs is iVGA_VS registered.
- States:
  - IDLE: after reset. On a boundary, go to SYNC with no report, because the first frame is partial.
  - SYNC: waiting for the first active pixel. iVGA_BLANK_N=1 goes to ACTIVE. A boundary goes to REPORT with count 0.
  - ACTIVE: a boundary goes to REPORT.
  - REPORT: lasts one cycle, then goes to SYNC unconditionally.
- acc counts cycles with iVGA_BLANK_N & match.
  - It saturates at 2^CNT_W-1.
  - On the boundary edge, frame_count <= acc and acc is cleared. A match in the boundary cycle counts toward the closing frame.
- Threshold update in REPORT, with manual mode or auto_en=0:
  - thresh <= sw_thresh.
- Threshold update in REPORT, auto mode:
  - If frame_count > target+HYST: thresh <= min(thresh+STEP, 255).
  - If frame_count + HYST < target: thresh <= max(thresh-STEP, 0).
  - Otherwise hold.
  - Compute sums at CNT_W+1 bits with no wrap.
- Position:
  - pix_x increments on each active cycle.
  - On the falling edge of iVGA_BLANK_N with pix_x≠0: pix_x <= 0 and pix_y++.
  - A boundary clears both.
- Overflow is set sticky, cleared only by reset, on either of:
  - an active pixel with pix_x=WIDTH-1 already consumed; pix_x saturates at WIDTH-1.
  - a new line when pix_y=HEIGHT-1; pix_y saturates.
- Reset values:
  - thresh=8'd128.
  - frame_count=0, count_valid=0, pix_x=0, pix_y=0, overflow=0.
  - acc=0, prev_vs=1, state=IDLE.
- Reset mid-frame: all state is cleared asynchronously, and the next frame after release is treated as partial (IDLE).

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Boundary detected in cycle N:
  - In cycle N+1: state=REPORT, count_valid=1, frame_count valid.
  - From cycle N+2: the new thresh is valid.
- thresh is constant from N+2 until the next boundary. The VS pulse lies inside vertical blank, so the entire active area sees one threshold.
- pix_x and pix_y lag the input pixel by one cycle, aligned with the filter's registered output.
- Changes to sw_thresh, auto_en and target mid-frame have no effect until REPORT.

## Configuration
- FILTER_AUTO_THRESH_EN defined: auto-adjust logic is compiled in, and auto_en, target, STEP and HYST are active.
- Undefined:
  - REPORT always loads sw_thresh.
  - auto_en and target are ignored (ports remain and are left unconnected internally).
  - The comparator and adder logic is absent.

## Structure
- filter_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, SYNC, ACTIVE, REPORT}.
  - THRESH_RESET=8'd128.
  - A clog2-based count-width helper.
- Sub-module vga_pos_counter provides pix_x, pix_y, overflow and boundary detection. It is instantiated once.

## Test plan
Use the standard timing generator with WIDTH=10 and HEIGHT=10.
- Reset release, then first boundary → no count_valid; state goes to SYNC; thresh=128. Asserting reset_n low mid-ACTIVE → all outputs zero, thresh=128, immediately.
- FILTER_AUTO_THRESH_EN undefined, sw_thresh 0x40 changed mid-frame → thresh stays 128 until 2 cycles after VS fall, then becomes 0x40.
- match=1 on all pixels → frame_count=100, count_valid high exactly 1 cycle. match=0 frame → frame_count=0.
- Auto, target=20, HYST=4, all match → thresh steps 128→129→130 per frame. Preloaded at 255 → stays 255.
- Auto: 10 matches/frame → thresh decreases 1/frame and saturates at 0. 18 matches → unchanged (deadband).
- Line of 11 active pixels → overflow=1 and sticky; pix_x holds 9; clears only on reset.

Source files
------------

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the frame-synchronous threshold filter controller.
package filter_ctrl_pkg;

    localparam int unsigned THRESH_W = 8;
    localparam int unsigned PIX_X_W  = 10;
    localparam int unsigned PIX_Y_W  = 9;

    localparam logic [THRESH_W-1:0] THRESH_RESET = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        REPORT
    } ctrl_state_t;

    // Bits needed to hold counts 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Pixel position tracker: derives column/line of the previous input pixel from
// BLANK_N edges, detects the VS-fall frame boundary and flags timing overruns.
module vga_pos_counter
    import filter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vs_i,
    input  logic               blank_n_i,
    output logic               boundary_c_o,
    output logic [PIX_X_W-1:0] pix_x_o,
    output logic [PIX_Y_W-1:0] pix_y_o,
    output logic               overflow_o
);

    localparam logic [PIX_X_W-1:0] X_LAST = PIX_X_W'(WIDTH - 1);
    localparam logic [PIX_Y_W-1:0] Y_LAST = PIX_Y_W'(HEIGHT - 1);

    logic               prev_vs_q;
    logic               prev_blank_q;
    logic [PIX_X_W-1:0] pix_x_q, pix_x_d;
    logic [PIX_Y_W-1:0] pix_y_q, pix_y_d;
    logic               y_full_q, y_full_d;
    logic               overflow_q, overflow_d;
    logic               line_start_c;
    logic               line_end_c;

    assign boundary_c_o = prev_vs_q & ~vs_i;
    assign line_start_c = blank_n_i & ~prev_blank_q;
    assign line_end_c   = prev_blank_q & ~blank_n_i & (pix_x_q != '0);

    // y_full marks that the last legal line has ended; a further line is an overrun.
    always_comb begin
        pix_x_d    = pix_x_q;
        pix_y_d    = pix_y_q;
        y_full_d   = y_full_q;
        overflow_d = overflow_q;
        if (boundary_c_o) begin
            pix_x_d  = '0;
            pix_y_d  = '0;
            y_full_d = 1'b0;
        end else if (blank_n_i) begin
            if (line_start_c) begin
                pix_x_d = '0;
                if (y_full_q) begin
                    overflow_d = 1'b1;
                end
            end else if (pix_x_q == X_LAST) begin
                overflow_d = 1'b1;
            end else begin
                pix_x_d = pix_x_q + PIX_X_W'(1);
            end
        end else if (line_end_c) begin
            pix_x_d = '0;
            if (pix_y_q == Y_LAST) begin
                y_full_d = 1'b1;
            end else begin
                pix_y_d = pix_y_q + PIX_Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_vs_q    <= 1'b1;
            prev_blank_q <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            y_full_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            prev_vs_q    <= vs_i;
            prev_blank_q <= blank_n_i;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            y_full_q     <= y_full_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pix_x_o    = pix_x_q;
    assign pix_y_o    = pix_y_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame controller for the VGA threshold filter: counts matches per frame and
// updates the threshold once per frame. FILTER_AUTO_THRESH_EN adds closed-loop auto-adjust.
module filter_frame_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned CNT_W  = cnt_width(WIDTH * HEIGHT),
    parameter int unsigned STEP   = 1,
    parameter int unsigned HYST   = 64
) (
    input  logic                VGA_CLK,
    input  logic                reset_n,
    input  logic                iVGA_HS,
    input  logic                iVGA_VS,
    input  logic                iVGA_BLANK_N,
    input  logic                match,
    input  logic [THRESH_W-1:0] sw_thresh,
    input  logic                auto_en,
    input  logic [CNT_W-1:0]    target,
    output logic [THRESH_W-1:0] thresh,
    output logic [CNT_W-1:0]    frame_count,
    output logic                count_valid,
    output logic [PIX_X_W-1:0]  pix_x,
    output logic [PIX_Y_W-1:0]  pix_y,
    output logic                overflow
);

    ctrl_state_t         state_q, state_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    frame_count_q, frame_count_d;
    logic                count_valid_q, count_valid_d;
    logic [THRESH_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0]    acc_sum_c;
    logic [THRESH_W-1:0] report_thresh_c;
    logic                boundary_c;
    logic                unused_c;

    vga_pos_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_pos (
        .clk_i       (VGA_CLK),
        .rst_ni      (reset_n),
        .vs_i        (iVGA_VS),
        .blank_n_i   (iVGA_BLANK_N),
        .boundary_c_o(boundary_c),
        .pix_x_o     (pix_x),
        .pix_y_o     (pix_y),
        .overflow_o  (overflow)
    );

    // Saturating count including the current cycle, so a boundary-cycle match still lands.
    assign acc_sum_c = (iVGA_BLANK_N && match && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;

`ifdef FILTER_AUTO_THRESH_EN
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned UP_W  = THRESH_W + 1;

    logic [SUM_W-1:0] fc_ext_c, fc_plus_hyst_c, target_ext_c, target_plus_hyst_c;
    logic [UP_W-1:0]  thresh_up_c;
    logic [THRESH_W-1:0] thresh_dn_c;

    // Deadband comparison at one extra bit so neither sum can wrap.
    always_comb begin
        fc_ext_c           = SUM_W'(frame_count_q);
        target_ext_c       = SUM_W'(target);
        fc_plus_hyst_c     = fc_ext_c + SUM_W'(HYST);
        target_plus_hyst_c = target_ext_c + SUM_W'(HYST);
        thresh_up_c        = UP_W'(thresh_q) + UP_W'(STEP);
        thresh_dn_c        = (thresh_q < THRESH_W'(STEP)) ? '0 : thresh_q - THRESH_W'(STEP);
        report_thresh_c    = thresh_q;
        if (!auto_en) begin
            report_thresh_c = sw_thresh;
        end else if (fc_ext_c > target_plus_hyst_c) begin
            report_thresh_c = thresh_up_c[UP_W-1] ? '1 : thresh_up_c[THRESH_W-1:0];
        end else if (fc_plus_hyst_c < target_ext_c) begin
            report_thresh_c = thresh_dn_c;
        end
    end

    assign unused_c = iVGA_HS;
`else
    assign report_thresh_c = sw_thresh;
    assign unused_c        = ^{iVGA_HS, auto_en, target, 32'(STEP), 32'(HYST)};
`endif

    // First boundary after reset closes a partial frame, so IDLE never reports.
    always_comb begin
        state_d       = state_q;
        acc_d         = boundary_c ? '0 : acc_sum_c;
        frame_count_d = frame_count_q;
        count_valid_d = 1'b0;
        thresh_d      = thresh_q;
        case (state_q)
            IDLE: begin
                if (boundary_c) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (boundary_c) begin
                    state_d       = REPORT;
                    frame_count_d = '0;
                    count_valid_d = 1'b1;
                end else if (iVGA_BLANK_N) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (boundary_c) begin
                    state_d       = REPORT;
                    frame_count_d = acc_sum_c;
                    count_valid_d = 1'b1;
                end
            end
            REPORT: begin
                state_d  = SYNC;
                thresh_d = report_thresh_c;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            frame_count_q <= '0;
            count_valid_q <= 1'b0;
            thresh_q      <= THRESH_RESET;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            frame_count_q <= frame_count_d;
            count_valid_q <= count_valid_d;
            thresh_q      <= thresh_d;
        end
    end

    assign thresh      = thresh_q;
    assign frame_count = frame_count_q;
    assign count_valid = count_valid_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl on a 10x10 frame: frame-level reference model compared
// every cycle, plus hand-computed literal checks after each frame.
module tb_filter_frame_ctrl;

    localparam int W_P    = 10;
    localparam int H_P    = 10;
    localparam int CNT_WP = 19;
    localparam int STEP_P = 1;
    localparam int HYST_P = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              vs = 1'b1;
    logic              hs = 1'b1;
    logic              blank_n = 1'b0;
    logic              match = 1'b0;
    logic [7:0]        sw_thresh = 8'h20;
    logic              auto_en = 1'b0;
    logic [CNT_WP-1:0] target = '0;
    logic [7:0]        thresh;
    logic [CNT_WP-1:0] frame_count;
    logic              count_valid;
    logic [9:0]        pix_x;
    logic [8:0]        pix_y;
    logic              overflow;

    int drv_col  = 0;
    int drv_line = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int cv_pulses = 0;

    filter_frame_ctrl #(
        .WIDTH (W_P),
        .HEIGHT(H_P),
        .CNT_W (CNT_WP),
        .STEP  (STEP_P),
        .HYST  (HYST_P)
    ) dut (
        .VGA_CLK     (clk),
        .reset_n     (rst_n),
        .iVGA_HS     (hs),
        .iVGA_VS     (vs),
        .iVGA_BLANK_N(blank_n),
        .match       (match),
        .sw_thresh   (sw_thresh),
        .auto_en     (auto_en),
        .target      (target),
        .thresh      (thresh),
        .frame_count (frame_count),
        .count_valid (count_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

`ifdef FILTER_AUTO_THRESH_EN
    function automatic int model_thresh(input int cur, input int fc, input int sw,
                                        input bit ae, input int tg);
        if (!ae) return sw;
        if (fc > tg + HYST_P) return (cur + STEP_P > 255) ? 255 : cur + STEP_P;
        if (fc + HYST_P < tg) return (cur < STEP_P) ? 0 : cur - STEP_P;
        return cur;
    endfunction
`endif

    // Reference model: frame events derived from stimulus and the spec's rules.
    int m_acc = 0;
    bit m_prev_vs = 1'b1;
    bit m_seen = 1'b0;
    bit m_rep = 1'b0;
    bit pos_known = 1'b0;
    int exp_fc = 0;
    bit exp_cv = 1'b0;
    int exp_th = 128;
    bit exp_ovf = 1'b0;
    bit exp_pv = 1'b0;
    int exp_px = 0;
    int exp_py = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_prev_vs = 1'b1; m_seen = 1'b0; m_rep = 1'b0; pos_known = 1'b0;
            exp_fc = 0; exp_cv = 1'b0; exp_th = 128; exp_ovf = 1'b0; exp_pv = 1'b0;
            exp_px = 0; exp_py = 0;
        end else begin
            exp_cv = 1'b0;
            if (m_rep) begin
`ifdef FILTER_AUTO_THRESH_EN
                exp_th = model_thresh(exp_th, exp_fc, int'(sw_thresh), auto_en, int'(target));
`else
                exp_th = int'(sw_thresh);
`endif
                m_rep = 1'b0;
            end
            if (blank_n && match) m_acc++;
            exp_pv = 1'b0;
            if (m_prev_vs && !vs) begin
                if (m_seen) begin
                    exp_fc = m_acc;
                    exp_cv = 1'b1;
                    m_rep  = 1'b1;
                end
                m_seen = 1'b1;
                m_acc = 0;
                pos_known = 1'b1;
            end else if (blank_n && pos_known) begin
                exp_pv = 1'b1;
                exp_px = (drv_col > W_P - 1) ? W_P - 1 : drv_col;
                exp_py = (drv_line > H_P - 1) ? H_P - 1 : drv_line;
                if (drv_col >= W_P || drv_line >= H_P) exp_ovf = 1'b1;
            end
            m_prev_vs = vs;
        end
    end

    always @(negedge clk) begin
        if (count_valid) cv_pulses++;
        check("count_valid", int'(count_valid), int'(exp_cv));
        check("frame_count", int'(frame_count), exp_fc);
        check("thresh", int'(thresh), exp_th);
        check("overflow", int'(overflow), int'(exp_ovf));
        if (pos_known && exp_pv) begin
            check("pix_x", int'(pix_x), exp_px);
            check("pix_y", int'(pix_y), exp_py);
        end
    end

    task automatic drive(input bit v, input bit h, input bit b, input bit m,
                         input int c, input int l);
        @(posedge clk);
        #1;
        vs = v; hs = h; blank_n = b; match = m; drv_col = c; drv_line = l;
    endtask

    // One frame: first nmatch active pixels match; long_line gets one extra pixel.
    task automatic send_frame(input int lines, input int ppl, input int nmatch,
                              input int long_line, input int sw_mid);
        int idx;
        idx = 0;
        for (int l = 0; l < lines; l++) begin
            if (l == 5 && sw_mid >= 0) sw_thresh = 8'(sw_mid);
            drive(1, 1, 0, 0, 0, 0);
            drive(1, 1, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0);
            drive(1, 1, 0, 0, 0, 0);
            drive(1, 1, 0, 0, 0, 0);
            for (int c = 0; c < ppl + ((l == long_line) ? 1 : 0); c++) begin
                drive(1, 1, 1, idx < nmatch, c, l);
                idx++;
            end
        end
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_thresh"}, int'(thresh), 128);
        check({tag, "_frame_count"}, int'(frame_count), 0);
        check({tag, "_count_valid"}, int'(count_valid), 0);
        check({tag, "_pix_x"}, int'(pix_x), 0);
        check({tag, "_pix_y"}, int'(pix_y), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1;
        check_zeroed("rst");
        rst_n = 1'b1;

        p0 = cv_pulses;
        send_frame(10, 10, 100, -1, -1);
        check("A_pulses", cv_pulses - p0, 0);
        check("A_thresh", int'(thresh), 128);

        p0 = cv_pulses;
        send_frame(10, 10, 100, -1, 8'h40);
        check("B_pulses", cv_pulses - p0, 1);
        check("B_count", int'(frame_count), 100);
        check("B_thresh", int'(thresh), 8'h40);

        p0 = cv_pulses;
        send_frame(10, 10, 0, -1, -1);
        check("C_pulses", cv_pulses - p0, 1);
        check("C_count", int'(frame_count), 0);
        check("C_thresh", int'(thresh), 8'h40);

        sw_thresh = 8'd128;
        send_frame(10, 10, 37, -1, -1);
        check("D_count", int'(frame_count), 37);
        check("D_thresh", int'(thresh), 128);

`ifdef FILTER_AUTO_THRESH_EN
        auto_en = 1'b1; target = 19'd20;
        send_frame(10, 10, 100, -1, -1);
        check("E_thresh", int'(thresh), 129);
        send_frame(10, 10, 100, -1, -1);
        check("F_thresh", int'(thresh), 130);
        auto_en = 1'b0; sw_thresh = 8'd255;
        send_frame(10, 10, 100, -1, -1);
        check("G_thresh", int'(thresh), 255);
        auto_en = 1'b1;
        send_frame(10, 10, 100, -1, -1);
        check("H_thresh_sat", int'(thresh), 255);
        auto_en = 1'b0; sw_thresh = 8'd2;
        send_frame(10, 10, 10, -1, -1);
        check("I_thresh", int'(thresh), 2);
        auto_en = 1'b1;
        send_frame(10, 10, 10, -1, -1);
        check("J_thresh", int'(thresh), 1);
        send_frame(10, 10, 10, -1, -1);
        check("K_thresh", int'(thresh), 0);
        send_frame(10, 10, 10, -1, -1);
        check("L_thresh_floor", int'(thresh), 0);
        auto_en = 1'b0; sw_thresh = 8'd50;
        send_frame(10, 10, 18, -1, -1);
        check("M_thresh", int'(thresh), 50);
        auto_en = 1'b1;
        send_frame(10, 10, 18, -1, -1);
        check("N_count", int'(frame_count), 18);
        check("N_thresh_deadband", int'(thresh), 50);
`else
        auto_en = 1'b1; target = 19'd20; sw_thresh = 8'h33;
        send_frame(10, 10, 100, -1, -1);
        check("E_thresh_manual", int'(thresh), 8'h33);
        send_frame(10, 10, 10, -1, -1);
        check("F_thresh_manual", int'(thresh), 8'h33);
`endif

        auto_en = 1'b0; sw_thresh = 8'h11;
        p0 = cv_pulses;
        fork
            send_frame(10, 10, 100, -1, -1);
            begin
                repeat (55) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check_zeroed("midrst");
                @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
        join
        check("R_pulses", cv_pulses - p0, 0);
        check("R_thresh", int'(thresh), 128);

        p0 = cv_pulses;
        send_frame(11, 10, 100, -1, -1);
        check("S_pulses", cv_pulses - p0, 1);
        check("S_overflow", int'(overflow), 1);
        check("S_count", int'(frame_count), 100);
        check("S_thresh", int'(thresh), 8'h11);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zeroed("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_frame(1, 10, 0, -1, -1);
        send_frame(10, 10, 100, 3, -1);
        check("U_overflow", int'(overflow), 1);
        check("U_count", int'(frame_count), 100);
        send_frame(10, 10, 5, -1, -1);
        check("V_overflow_sticky", int'(overflow), 1);
        check("V_count", int'(frame_count), 5);

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst3_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
